// File: rtl/mem.sv
// MEM stage: holds the EX/MEM pipeline register, keeps load data alive across
// stalls and extracts sized/sign-extended load results for WB and ID forwarding.
module mem #(
  parameter int StallBus     = 6,
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_ID_WD = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  localparam logic STOP = 1'b1;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [EX_TO_MEM_WD-1:0] bus_q;
  logic [EX_TO_MEM_WD-1:0] bus_d;
  logic                    first_cyc_q;
  logic                    first_cyc_d;
  logic [31:0]             rdata_hold_q;
  logic [31:0]             rdata_hold_d;

  logic [31:0] pc_s;
  logic        data_ram_en_s;
  logic [3:0]  data_ram_wen_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;
  logic [2:0]  mem_op_s;
  logic [31:0] ld_word_s;
  logic [31:0] ld_data_s;
  logic        is_load_s;
  logic [31:0] rf_wdata_s;
  logic        unused_bits_s;

  // Pick the addressed byte or halfword of a loaded word and extend it.
  function automatic logic [31:0] load_extract(
    input logic [2:0]  op,
    input logic [1:0]  addr,
    input logic [31:0] word
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (addr[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (op)
      OP_LW:   res_v = word;
      OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res_v = {24'd0, byte_v};
      OP_LH:   res_v = {{16{half_v[15]}}, half_v};
      OP_LHU:  res_v = {16'd0, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // Next-state for the pipeline register, first-cycle flag and held read data.
  always_comb begin
    bus_d        = bus_q;
    first_cyc_d  = 1'b0;
    rdata_hold_d = rdata_hold_q;
    if (first_cyc_q) begin
      rdata_hold_d = data_sram_rdata;
    end else begin
      rdata_hold_d = rdata_hold_q;
    end
    if (flush) begin
      bus_d       = '0;
      first_cyc_d = 1'b0;
    end else if (stall[3] == STOP && stall[4] != STOP) begin
      bus_d       = '0;
      first_cyc_d = 1'b0;
    end else if (stall[3] != STOP) begin
      bus_d       = ex_to_mem_bus;
      first_cyc_d = 1'b1;
    end else begin
      bus_d       = bus_q;
      first_cyc_d = 1'b0;
    end
  end

  // State registers; reset discards any held load.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q        <= '0;
      first_cyc_q  <= 1'b0;
      rdata_hold_q <= 32'd0;
    end else begin
      bus_q        <= bus_d;
      first_cyc_q  <= first_cyc_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign {pc_s, data_ram_en_s, data_ram_wen_s, sel_rf_res_s, rf_we_s,
          rf_waddr_s, ex_result_s, mem_op_s} = bus_q;

  // SRAM output is only valid in the first MEM cycle; afterwards use the copy.
  assign ld_word_s = first_cyc_q ? data_sram_rdata : rdata_hold_q;
  assign ld_data_s = load_extract(mem_op_s, ex_result_s[1:0], ld_word_s);

  // A store never returns memory data, whatever sel_rf_res says.
  assign is_load_s  = sel_rf_res_s && (data_ram_wen_s == 4'd0);
  assign rf_wdata_s = is_load_s ? ld_data_s : ex_result_s;

  assign mem_to_wb_bus = {pc_s, rf_we_s, rf_waddr_s, rf_wdata_s};
  assign mem_to_id_bus = {rf_we_s, rf_waddr_s, rf_wdata_s};

  assign unused_bits_s = ^{stall, data_ram_en_s};

endmodule

// File: tb/tb_mem.sv
// Directed bench for the MEM stage: load extraction, stall hold, bubble,
// flush and reset precedence, with hand-computed expected bus values.
module tb_mem;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;

  int checks;
  int errors;

  logic [69:0] exp_wb;

  mem dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stall          (stall),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus  (mem_to_wb_bus),
    .mem_to_id_bus  (mem_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [78:0] mk(input logic [31:0] pc, input logic en,
                                     input logic [3:0] wen, input logic sel,
                                     input logic we, input logic [4:0] waddr,
                                     input logic [31:0] res, input logic [2:0] op);
    return {pc, en, wen, sel, we, waddr, res, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 6'd0;
    ex_to_mem_bus = mk(32'h400, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h10, 3'd0);
    data_sram_rdata = 32'hCAFEF00D;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL reset_wb: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    checks++;
    if (mem_to_id_bus !== 38'd0) begin
      errors++;
      $display("FAIL reset_id: got %h expected %h", mem_to_id_bus, 38'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    stall = 6'd0;
    ex_to_mem_bus = mk(32'h0000_1000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd5, 32'h100, 3'd0);
    data_sram_rdata = 32'hDEADBEEF;
    step();
    exp_wb = {32'h0000_1000, 1'b1, 5'd5, 32'hDEADBEEF};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      errors++;
      $display("FAIL lw_wb: got %h expected %h", mem_to_wb_bus, exp_wb);
    end
    checks++;
    if (mem_to_id_bus !== exp_wb[37:0]) begin
      errors++;
      $display("FAIL lw_id: got %h expected %h", mem_to_id_bus, exp_wb[37:0]);
    end
  endtask

  task automatic test_byte_loads();
    logic [2:0]  op_v   [5];
    logic [31:0] addr_v [5];
    logic [31:0] rd_v   [5];
    logic [31:0] exp_v  [5];
    op_v[0] = 3'd1; addr_v[0] = 32'h203; rd_v[0] = 32'h80123456; exp_v[0] = 32'hFFFFFF80;
    op_v[1] = 3'd2; addr_v[1] = 32'h203; rd_v[1] = 32'h80123456; exp_v[1] = 32'h00000080;
    op_v[2] = 3'd1; addr_v[2] = 32'h200; rd_v[2] = 32'h80123456; exp_v[2] = 32'h00000056;
    op_v[3] = 3'd1; addr_v[3] = 32'h201; rd_v[3] = 32'h0000A500; exp_v[3] = 32'hFFFFFFA5;
    op_v[4] = 3'd2; addr_v[4] = 32'h202; rd_v[4] = 32'h00C30000; exp_v[4] = 32'h000000C3;
    for (int i = 0; i < 5; i++) begin
      ex_to_mem_bus = mk(32'h2000 + i, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, addr_v[i], op_v[i]);
      data_sram_rdata = rd_v[i];
      step();
      exp_wb = {32'h2000 + i, 1'b1, 5'd7, exp_v[i]};
      checks++;
      if (mem_to_wb_bus !== exp_wb) begin
        errors++;
        $display("FAIL byte_load[%0d]: got %h expected %h", i, mem_to_wb_bus, exp_wb);
      end
    end
  endtask

  task automatic test_half_loads();
    logic [2:0]  op_v   [5];
    logic [31:0] addr_v [5];
    logic [31:0] exp_v  [5];
    op_v[0] = 3'd4; addr_v[0] = 32'h302; exp_v[0] = 32'h0000BEEF;
    op_v[1] = 3'd3; addr_v[1] = 32'h302; exp_v[1] = 32'hFFFFBEEF;
    op_v[2] = 3'd3; addr_v[2] = 32'h303; exp_v[2] = 32'hFFFFBEEF;
    op_v[3] = 3'd3; addr_v[3] = 32'h301; exp_v[3] = 32'h00001234;
    op_v[4] = 3'd5; addr_v[4] = 32'h303; exp_v[4] = 32'hBEEF1234;
    data_sram_rdata = 32'hBEEF1234;
    for (int i = 0; i < 5; i++) begin
      ex_to_mem_bus = mk(32'h3000 + i, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, addr_v[i], op_v[i]);
      step();
      exp_wb = {32'h3000 + i, 1'b1, 5'd9, exp_v[i]};
      checks++;
      if (mem_to_wb_bus !== exp_wb) begin
        errors++;
        $display("FAIL half_load[%0d]: got %h expected %h", i, mem_to_wb_bus, exp_wb);
      end
    end
  endtask

  task automatic test_stall_hold();
    stall = 6'd0;
    ex_to_mem_bus = mk(32'h4000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd11, 32'h40, 3'd0);
    data_sram_rdata = 32'h11111111;
    step();
    exp_wb = {32'h4000, 1'b1, 5'd11, 32'h11111111};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      errors++;
      $display("FAIL stall_first: got %h expected %h", mem_to_wb_bus, exp_wb);
    end
    stall = 6'b011000;
    ex_to_mem_bus = mk(32'h4004, 1'b1, 4'd0, 1'b0, 1'b1, 5'd12, 32'h99, 3'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      data_sram_rdata = 32'h22222222;
      #1;
      checks++;
      if (mem_to_wb_bus !== exp_wb) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", c, mem_to_wb_bus, exp_wb);
      end
    end
    stall = 6'd0;
  endtask

  task automatic test_bubble();
    stall = 6'd0;
    ex_to_mem_bus = mk(32'h5000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd2, 32'h77, 3'd0);
    step();
    stall = 6'b001000;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0 || mem_to_id_bus !== 38'd0) begin
      errors++;
      $display("FAIL bubble: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    stall = 6'd0;
  endtask

  task automatic test_flush();
    stall = 6'd0; flush = 1'b0;
    ex_to_mem_bus = mk(32'h6000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd4, 32'h66, 3'd0);
    step();
    flush = 1'b1;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL flush: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    flush = 1'b0;
    step();
    flush = 1'b1; stall = 6'b011000;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0 || mem_to_id_bus !== 38'd0) begin
      errors++;
      $display("FAIL flush_vs_stall: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    flush = 1'b0; stall = 6'd0;
  endtask

  task automatic test_alu();
    stall = 6'd0;
    ex_to_mem_bus = mk(32'h7000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd8, 32'h12345678, 3'd1);
    data_sram_rdata = 32'hFFFFFFFF;
    step();
    exp_wb = {32'h7000, 1'b1, 5'd8, 32'h12345678};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      errors++;
      $display("FAIL alu_wb: got %h expected %h", mem_to_wb_bus, exp_wb);
    end
    checks++;
    if (mem_to_id_bus !== exp_wb[37:0]) begin
      errors++;
      $display("FAIL alu_id: got %h expected %h", mem_to_id_bus, exp_wb[37:0]);
    end
  endtask

  task automatic test_store();
    ex_to_mem_bus = mk(32'h7100, 1'b1, 4'hF, 1'b1, 1'b0, 5'd0, 32'hABCD0000, 3'd0);
    data_sram_rdata = 32'h55555555;
    step();
    exp_wb = {32'h7100, 1'b0, 5'd0, 32'hABCD0000};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      errors++;
      $display("FAIL store: got %h expected %h", mem_to_wb_bus, exp_wb);
    end
  endtask

  task automatic test_rst_mid_stall();
    stall = 6'd0;
    ex_to_mem_bus = mk(32'h8000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd13, 32'h80, 3'd0);
    data_sram_rdata = 32'h33333333;
    step();
    stall = 6'b011000;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL rst_mid_stall: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL rst_then_hold: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    stall = 6'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; flush = 1'b0; stall = 6'd0;
    ex_to_mem_bus = '0; data_sram_rdata = 32'd0;
    test_reset();
    test_lw();
    test_byte_loads();
    test_half_loads();
    test_stall_hold();
    test_bubble();
    test_flush();
    test_alu();
    test_store();
    test_rst_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
Parameters (name, default, meaning)
REQ-001 The block SHALL use `StallBus`, default 6, as the width of the stall vector.
REQ-002 The block SHALL use `EX_TO_MEM_WD`, default 79, as the width of the EX-to-MEM bus.
REQ-003 The block SHALL use `MEM_TO_WB_WD`, default 70, for the MEM-to-WB bus and `MEM_TO_ID_WD`, default 38, for the forwarding bus.

Ports (name, direction, width, meaning)
REQ-004 clk, input, 1, the single clock; all state SHALL update on its rising edge only.
REQ-005 rst, input, 1, reset; synchronous and active-high.
REQ-006 flush, input, 1, clears the MEM pipeline register.
REQ-007 stall, input, `StallBus`, pipeline stall vector; Stop=1, NoStop=0.
REQ-008 ex_to_mem_bus, input, 79, fields {pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0], mem_op[2:0]}, MSB first.
REQ-009 data_sram_rdata, input, 32, synchronous SRAM read data, valid one cycle after EX issued the request.
REQ-010 mem_to_wb_bus, output, 70, fields {pc, rf_we, rf_waddr, rf_wdata}.
REQ-011 mem_to_id_bus, output, 38, forwarding fields {rf_we, rf_waddr, rf_wdata}.

Function
REQ-012 Pipeline register update, in priority order:
- rst=1 -> register cleared to 0.
- flush=1 -> register cleared to 0.
- stall[3]=Stop with stall[4]=NoStop -> register loaded with 0 (bubble).
- stall[3]=NoStop -> register loaded from ex_to_mem_bus.
- Otherwise -> register holds its value.
REQ-013 first_cyc SHALL be a register that is set to 1 in the cycle after a load from ex_to_mem_bus, and cleared to 0 after rst, flush, a bubble, or a hold.
REQ-014 rdata_hold SHALL capture data_sram_rdata whenever first_cyc=1, and hold its value otherwise.
REQ-015 The block SHALL compute ld_word = first_cyc ? data_sram_rdata : rdata_hold, so that a load stalled in MEM keeps its data after the SRAM output changes.
REQ-016 Load extraction SHALL use addr = ex_result[1:0]:
- mem_op 000 LW -> the full word.
- 001 LB -> byte addr, sign-extended.
- 010 LBU -> byte addr, zero-extended.
- 011 LH -> half ex_result[1], sign-extended.
- 100 LHU -> half ex_result[1], zero-extended.
- 101..111 -> treated as LW.
REQ-017 Byte n SHALL be ld_word[8n+7:8n]; half 0 is [15:0] and half 1 is [31:16]; ex_result[0] SHALL be ignored for halfword loads.
REQ-018 rf_wdata SHALL equal sel_rf_res ? extracted load data : ex_result.
REQ-019 pc, rf_we and rf_waddr SHALL pass through from the register unchanged.
REQ-020 Both output buses SHALL be combinational functions of the register and data inputs, with zero added latency; the data is forwarded to ID in the same cycle it is presented to WB.
REQ-021 A bubble or a cleared register SHALL yield rf_we=0, so no write and no forward occur.
REQ-022 When flush and stall are asserted together, flush SHALL win.
REQ-023 A store (data_ram_wen≠0) SHALL never drive sel_rf_res-based load data; its rf_we is as supplied by EX.

Reset
REQ-024 While rst=1, the pipeline register, first_cyc and rdata_hold SHALL be 0.
REQ-025 The cycle after rst=1, all outputs SHALL be 0.
REQ-026 If rst is asserted mid-stall, clear SHALL take precedence and the held load SHALL be discarded.

Verification
REQ-027 Load LW at 0x100, rdata=0xDEADBEEF, no stall -> next cycle mem_to_wb rf_wdata=0xDEADBEEF, rf_we=1.
REQ-028 LB with addr[1:0]=3, rdata=0x80123456 -> 0xFFFFFF80; LBU with the same inputs -> 0x00000080.
REQ-029 LHU with addr[1:0]=2, rdata=0xBEEF1234 -> 0x0000BEEF; LH with the same inputs -> 0xFFFFBEEF.
REQ-030 Load LW with rdata=0x11111111, stall[3]=stall[4]=Stop for 3 cycles while rdata changes to 0x22222222 -> rf_wdata stays 0x11111111 throughout.
REQ-031 stall[3]=Stop, stall[4]=NoStop -> next cycle rf_we=0 and the bus equals 0; with flush=1 and stall=0 -> next cycle the register is 0.
REQ-032 Non-load ALU result 0x12345678 with sel_rf_res=0 -> mem_to_wb and mem_to_id rf_wdata=0x12345678.
